// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end feeding the IF/ID pipeline register.
// It owns the PC, keeps one memory request in flight, holds a fetched
// instruction across a stall and squashes the wrong-path response of a
// request that was outstanding when a redirect arrived.
// Optional feature macro: IF_FETCH_PERF_EN (delivered/bubble counters).
//
// Handshake: imem_req_o is held high with imem_addr_o stable until a
// one-cycle imem_ack_i arrives. imem_rdata_i is sampled in the ack cycle.
// The memory must tolerate imem_req_o dropping without an ack on reset.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        IIWrite_o,
  output logic [31:0] PC_plus4_o,
  output logic [31:0] instruction_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        squash_q, squash_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;

  logic        req_w;
  logic        deliver_w;
  logic        bubble_w;
  logic [31:0] out_instr_w;
  logic [31:0] out_pc4_w;
  logic [31:0] redir_tgt_w;
  logic [31:0] addr_plus4_w;
  logic        unused_pc_lsb;

  // Redirect targets are word aligned; the two low bits are dropped.
  assign redir_tgt_w   = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  assign addr_plus4_w  = addr_q + 32'd4;

  // State, address, squash and hold registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= RESET_PC;
      squash_q     <= 1'b0;
      tgt_q        <= 32'd0;
      hold_instr_q <= 32'd0;
      hold_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      squash_q     <= squash_d;
      tgt_q        <= tgt_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  // Next-state logic and deliver/bubble selection; a redirect always wins.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    squash_d     = squash_q;
    tgt_d        = tgt_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    req_w        = 1'b0;
    deliver_w    = 1'b0;
    bubble_w     = 1'b0;
    out_instr_w  = NOP_INSTR;
    out_pc4_w    = 32'd0;

    case (state_q)
      ST_IDLE: begin
        bubble_w = ~stall_i;
        state_d  = ST_FETCH;
        if (redirect_i) begin
          addr_d = redir_tgt_w;
        end
      end

      ST_FETCH: begin
        req_w = 1'b1;
        if (redirect_i) begin
          // Whatever arrives this cycle is on the wrong path.
          bubble_w = ~stall_i;
          if (imem_ack_i) begin
            addr_d   = redir_tgt_w;
            squash_d = 1'b0;
          end else begin
            // Request stays on the bus; its response is dropped later.
            squash_d = 1'b1;
            tgt_d    = redir_tgt_w;
          end
        end else if (!imem_ack_i) begin
          bubble_w = ~stall_i;
        end else if (squash_q) begin
          bubble_w = ~stall_i;
          addr_d   = tgt_q;
          squash_d = 1'b0;
        end else if (!stall_i) begin
          deliver_w   = 1'b1;
          out_instr_w = imem_rdata_i;
          out_pc4_w   = addr_plus4_w;
          addr_d      = addr_plus4_w;
        end else begin
          hold_instr_d = imem_rdata_i;
          hold_pc4_d   = addr_plus4_w;
          addr_d       = addr_plus4_w;
          state_d      = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (redirect_i) begin
          // Held instruction is discarded.
          bubble_w = ~stall_i;
          addr_d   = redir_tgt_w;
          state_d  = ST_FETCH;
        end else if (!stall_i) begin
          deliver_w   = 1'b1;
          out_instr_w = hold_instr_q;
          out_pc4_w   = hold_pc4_q;
          state_d     = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted.
  assign imem_req_o    = rst_n & req_w;
  assign imem_addr_o   = addr_q;
  assign IIWrite_o     = rst_n & (deliver_w | bubble_w);
  assign instruction_o = rst_n ? out_instr_w : 32'd0;
  assign PC_plus4_o    = rst_n ? out_pc4_w : 32'd0;
  assign dbg_state_o   = state_q;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Performance counters; stalled cycles are neither deliveries nor bubbles.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (deliver_w) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (bubble_w)  bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign fetch_cnt_o  = 32'd0;
  assign bubble_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed vector table plus hand-written reset and
// zero-wait sequences for if_fetch_unit (RESET_PC=0x100, NOP=0x13).
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        IIWrite_o;
  logic [31:0] PC_plus4_o;
  logic [31:0] instruction_o;
  logic [31:0] fetch_cnt_o;
  logic [31:0] bubble_cnt_o;
  logic [1:0]  dbg_state_o;

  if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .IIWrite_o     (IIWrite_o),
    .PC_plus4_o    (PC_plus4_o),
    .instruction_o (instruction_o),
    .fetch_cnt_o   (fetch_cnt_o),
    .bubble_cnt_o  (bubble_cnt_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  int exp_fetch = 0;
  int exp_bub   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef IF_FETCH_PERF_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iw;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                     input logic ak, input logic [31:0] rdat,
                     input logic e_req, input logic [31:0] e_addr, input logic e_iw,
                     input logic [31:0] e_instr, input logic [31:0] e_pc4);
    vecs.push_back('{st, rd, rpc, ak, rdat, e_req, e_addr, e_iw, e_instr, e_pc4});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic ak, input logic [31:0] rdat);
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_ack_i    = ak;
    imem_rdata_i  = rdat;
  endtask

  initial begin
    //  st rd rpc            ak rdata            req addr          iw instr          pc4
    add(0, 0, 32'h0,         0, 32'h0,          0, 32'h100,       1, NOP,           32'h0);   // 0 IDLE bubble
    add(0, 0, 32'h0,         1, 32'h100,        1, 32'h100,       1, 32'h100,       32'h104); // 1 first fetch
    add(0, 0, 32'h0,         1, 32'h104,        1, 32'h104,       1, 32'h104,       32'h108); // 2 back-to-back
    add(0, 0, 32'h0,         0, 32'h0,          1, 32'h108,       1, NOP,           32'h0);   // 3 wait
    add(0, 0, 32'h0,         0, 32'h0,          1, 32'h108,       1, NOP,           32'h0);   // 4 wait, addr stable
    add(0, 0, 32'h0,         1, 32'hAAAA0108,   1, 32'h108,       1, 32'hAAAA0108,  32'h10C); // 5
    add(1, 0, 32'h0,         1, 32'hBBBB010C,   1, 32'h10C,       0, 32'h0,         32'h0);   // 6 ack under stall
    add(1, 0, 32'h0,         0, 32'h0,          0, 32'h110,       0, 32'h0,         32'h0);   // 7 HOLD, no req
    add(1, 0, 32'h0,         0, 32'h0,          0, 32'h110,       0, 32'h0,         32'h0);   // 8
    add(0, 0, 32'h0,         0, 32'h0,          0, 32'h110,       1, 32'hBBBB010C,  32'h110); // 9 held delivered
    add(0, 0, 32'h0,         0, 32'h0,          1, 32'h110,       1, NOP,           32'h0);   // 10 next req addr+4
    add(0, 1, 32'h400,       0, 32'h0,          1, 32'h110,       1, NOP,           32'h0);   // 11 redirect in flight
    add(0, 0, 32'h0,         0, 32'h0,          1, 32'h110,       1, NOP,           32'h0);   // 12 old addr kept
    add(0, 0, 32'h0,         1, 32'hCCCC0110,   1, 32'h110,       1, NOP,           32'h0);   // 13 squashed
    add(0, 0, 32'h0,         1, 32'h400,        1, 32'h400,       1, 32'h400,       32'h404); // 14 target
    add(1, 1, 32'h203,       1, 32'hDDDD0404,   1, 32'h404,       0, 32'h0,         32'h0);   // 15 stall+redir+ack
    add(0, 0, 32'h0,         1, 32'h200,        1, 32'h200,       1, 32'h200,       32'h204); // 16 nothing held
    add(1, 0, 32'h0,         1, 32'hEEEE0204,   1, 32'h204,       0, 32'h0,         32'h0);   // 17 into HOLD
    add(0, 1, 32'h300,       0, 32'h0,          0, 32'h208,       1, NOP,           32'h0);   // 18 redirect in HOLD
    add(0, 1, 32'h500,       0, 32'h0,          1, 32'h300,       1, NOP,           32'h0);   // 19 squash
    add(0, 1, 32'h600,       0, 32'h0,          1, 32'h300,       1, NOP,           32'h0);   // 20 last wins
    add(0, 0, 32'h0,         1, 32'h300,        1, 32'h300,       1, NOP,           32'h0);   // 21 drop
    add(0, 0, 32'h0,         1, 32'hFFFF0600,   1, 32'h600,       1, 32'hFFFF0600,  32'h604); // 22
    add(1, 0, 32'h0,         0, 32'h0,          1, 32'h604,       0, 32'h0,         32'h0);   // 23 stall, no ack
    add(0, 0, 32'h0,         1, 32'h12345604,   1, 32'h604,       1, 32'h12345604,  32'h608); // 24
    add(0, 1, 32'hFFFFFFFF,  0, 32'h0,          1, 32'h608,       1, NOP,           32'h0);   // 25 unaligned target
    add(0, 0, 32'h0,         1, 32'h55555555,   1, 32'h608,       1, NOP,           32'h0);   // 26 drop
    add(0, 0, 32'h0,         1, 32'h0BADF00D,   1, 32'hFFFFFFFC,  1, 32'h0BADF00D,  32'h0);   // 27 pc+4 wraps
    add(0, 0, 32'h0,         0, 32'h0,          1, 32'h0,         1, NOP,           32'h0);   // 28 addr wrapped

    // ---- reset state ----
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst req", {31'd0, imem_req_o}, 32'd0);
    chk("rst addr", imem_addr_o, RST_PC);
    chk("rst iiwrite", {31'd0, IIWrite_o}, 32'd0);
    chk("rst instr", instruction_o, 32'd0);
    chk("rst pc4", PC_plus4_o, 32'd0);
    chk("rst fcnt", fetch_cnt_o, 32'd0);
    chk("rst bcnt", bubble_cnt_o, 32'd0);
    chk("rst state", {30'd0, dbg_state_o}, 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;

    // ---- table ----
    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d req", i), {31'd0, imem_req_o}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d addr", i), imem_addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d iiwrite", i), {31'd0, IIWrite_o}, {31'd0, vecs[i].e_iw});
      if (vecs[i].e_iw) begin
        chk($sformatf("v%0d instr", i), instruction_o, vecs[i].e_instr);
        chk($sformatf("v%0d pc4", i), PC_plus4_o, vecs[i].e_pc4);
      end
      chk($sformatf("v%0d fcnt", i), fetch_cnt_o, cnt_exp(exp_fetch));
      chk($sformatf("v%0d bcnt", i), bubble_cnt_o, cnt_exp(exp_bub));
      if (vecs[i].e_iw) begin
        if (vecs[i].e_instr == NOP && vecs[i].e_pc4 == 32'd0) exp_bub++;
        else exp_fetch++;
      end
      @(negedge clk_i);
    end

    // ---- reset mid-request abandons it and clears counters ----
    drive(0, 0, 32'h0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst req", {31'd0, imem_req_o}, 32'd0);
    chk("midrst addr", imem_addr_o, RST_PC);
    chk("midrst iiwrite", {31'd0, IIWrite_o}, 32'd0);
    chk("midrst instr", instruction_o, 32'd0);
    chk("midrst fcnt", fetch_cnt_o, 32'd0);
    chk("midrst bcnt", bubble_cnt_o, 32'd0);
    exp_fetch = 0;
    exp_bub   = 0;
    @(negedge clk_i);
    rst_n = 1'b1;
    #1;
    chk("rel idle req", {31'd0, imem_req_o}, 32'd0);
    chk("rel idle iiwrite", {31'd0, IIWrite_o}, 32'd1);
    chk("rel idle instr", instruction_o, NOP);
    exp_bub++;
    @(negedge clk_i);

    // ---- zero-wait memory: one instruction per cycle ----
    for (int k = 0; k < 8; k++) begin
      logic [31:0] a;
      a = RST_PC + 32'(4 * k);
      drive(0, 0, 32'h0, 1, a ^ 32'hA5A5_0000);
      exp_q.push_back(a ^ 32'hA5A5_0000);
      #1;
      chk($sformatf("zw%0d req", k), {31'd0, imem_req_o}, 32'd1);
      chk($sformatf("zw%0d addr", k), imem_addr_o, a);
      chk($sformatf("zw%0d iiwrite", k), {31'd0, IIWrite_o}, 32'd1);
      chk($sformatf("zw%0d instr", k), instruction_o, exp_q.pop_front());
      chk($sformatf("zw%0d pc4", k), PC_plus4_o, a + 32'd4);
      exp_fetch++;
      @(negedge clk_i);
    end
    drive(0, 0, 32'h0, 0, 32'h0);
    #1;
    chk("zw end addr", imem_addr_o, RST_PC + 32'd32);
    chk("zw fcnt", fetch_cnt_o, cnt_exp(exp_fetch));
    chk("zw bcnt", bubble_cnt_o, cnt_exp(exp_bub));

    // ---- report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end that issues requests to instruction memory and drives the write side of the IF/ID pipeline register (`PC_plus4_i`, `instruction_i`, `IIWrite`). It owns the program counter and tracks one outstanding memory request. It honours stalls from the hazard unit and applies branch/jump redirects from later stages. When no instruction is available it inserts NOP bubbles, and it squashes the wrong-path instruction of a request that is still in flight when a redirect arrives.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `NOP_INSTR`, default 32'h0000_0000: encoding driven for bubbles.
- `clk_i` in 1: clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall_i` in 1: hazard unit holds IF/ID; the fetch unit must not advance IF/ID.
- `redirect_i` in 1: single-cycle pulse; fetch continues from `redirect_pc_i`.
- `redirect_pc_i` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req_o` out 1: memory request valid.
- `imem_addr_o` out 32: request word address; stable while `imem_req_o`=1 and `imem_ack_i`=0.
- `imem_ack_i` in 1: one-cycle response; `imem_rdata_i` is valid in the same cycle.
- `imem_rdata_i` in 32: fetched instruction.
- `IIWrite_o` out 1: drives IF/ID `IIWrite`.
- `PC_plus4_o` out 32: drives IF/ID `PC_plus4_i`.
- `instruction_o` out 32: drives IF/ID `instruction_i`.
- `fetch_cnt_o` out 32: count of delivered instructions (see Configuration).
- `bubble_cnt_o` out 32: count of delivered bubbles (see Configuration).

## Operation
- Registers:
  - `state` ∈ {IDLE, FETCH, HOLD}.
  - `addr_r`: outstanding or next request address.
  - `squash_r`, `tgt_r`.
  - `hold_instr_r`, `hold_pc4_r`.
- **Deliver**: `IIWrite_o`=1, `instruction_o`=instruction, `PC_plus4_o`=address+4 (mod 2^32).
- **Bubble**: `IIWrite_o`=1, `instruction_o`=`NOP_INSTR`, `PC_plus4_o`=0.
- **Stalled**: whenever `stall_i`=1, `IIWrite_o`=0; the values on `instruction_o` and `PC_plus4_o` are don't-care.
- IDLE:
  - `imem_req_o`=0.
  - Bubble if `stall_i`=0.
  - Next state FETCH.
- FETCH: `imem_req_o`=1, `imem_addr_o`=`addr_r`. Per cycle:
  - No ack: bubble if `stall_i`=0.
  - Ack, `squash_r`=0, `stall_i`=0: deliver `imem_rdata_i`; `addr_r`+=4; stay in FETCH with a new request the next cycle.
  - Ack, `squash_r`=0, `stall_i`=1: capture the instruction into `hold_instr_r` and `hold_pc4_r`=`addr_r`+4; `addr_r`+=4; next state HOLD.
  - Ack, `squash_r`=1: discard data (bubble if `stall_i`=0); `addr_r`=`tgt_r`; clear `squash_r`.
- HOLD:
  - `imem_req_o`=0.
  - When `stall_i`=0: deliver hold registers; next state FETCH.
- Redirect (highest priority, evaluated in any state):
  - Output in the redirect cycle is a bubble (if `stall_i`=0); any instruction acked or held in that cycle is dropped.
  - FETCH without ack: `squash_r`=1, `tgt_r`=target. `imem_addr_o` stays at the old address until ack.
  - FETCH with ack in the same cycle: `addr_r`=target, no squash.
  - HOLD or IDLE: `addr_r`=target; next state FETCH.
  - Redirect while `squash_r`=1: overwrite `tgt_r` (last redirect wins).
- Stall plus redirect in the same cycle: the redirect takes effect and `IIWrite_o`=0.

## Timing
- Reset (async): state=IDLE, `addr_r`=`RESET_PC`, `squash_r`=0, hold registers=0.
- Output values while in reset:
  - `imem_req_o`=0, `imem_addr_o`=`RESET_PC`.
  - `IIWrite_o`=0, `instruction_o`=0, `PC_plus4_o`=0.
  - Counters=0.
- After `rst_n` deasserts: one IDLE cycle (bubble), then the first request at `RESET_PC`.
- `IIWrite_o`, `instruction_o`, `PC_plus4_o` are combinational from state, `imem_ack_i`, `imem_rdata_i` and `stall_i`; IF/ID registers them.
- Zero-wait memory (ack every request cycle) gives one delivered instruction per cycle, with back-to-back requests.
- Reset asserted mid-request abandons the request; the memory must tolerate `req` dropping without an ack.

## Configuration
- `IF_FETCH_PERF_EN` defined:
  - `fetch_cnt_o` increments on each deliver.
  - `bubble_cnt_o` increments on each bubble.
  - Both are 32-bit, wrap to 0, and are not changed by stalled cycles.
- Macro undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Reset release, `RESET_PC`=0x100, memory always acks with data=addr → IF/ID receives a bubble, then (0x104, 0x100), (0x108, 0x104), … with `IIWrite_o`=1 every cycle.
- Memory acks after 2 wait cycles → two bubbles between successive instructions; `imem_addr_o` is constant during the waits.
- Ack arrives with `stall_i`=1 for 3 cycles → `IIWrite_o`=0 for 3 cycles and no new request is issued; when stall drops, the held instruction is delivered and the next request goes to addr+4.
- Redirect to 0x400 while a request to 0x108 is outstanding, ack 2 cycles later → 0x108 data is never delivered (bubbles only); the next request is at 0x400.
- Redirect to 0x200 in the same cycle as an ack for 0x10C, with `stall_i`=1 → `IIWrite_o`=0, nothing is held, and the next request is at 0x200.
- With `IF_FETCH_PERF_EN`: 10 delivers and 4 bubbles → `fetch_cnt_o`=10, `bubble_cnt_o`=4; reset clears both.
